// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, sequences boot hold, run and halt,
// and steers redirects (trap, jump, branch) with misaligned-target trapping.
module pc_sequencer #(
  parameter int                   DATA_WIDTH_32 = 32,
  parameter logic [DATA_WIDTH_32-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH_32-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                   BOOT_DELAY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [DATA_WIDTH_32-1:0] branch_target,
  input  logic                     jump,
  input  logic [DATA_WIDTH_32-1:0] jump_target,
  input  logic                     trap,
  input  logic                     halt,
  output logic [DATA_WIDTH_32-1:0] pc,
  output logic [DATA_WIDTH_32-1:0] pc_plus4,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH_32-1:0] epc,
  output logic                     misaligned,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam state_t     RESET_STATE = (BOOT_DELAY == 0) ? ST_RUN : ST_BOOT;
  localparam logic [3:0] BOOT_CNT    = 4'(BOOT_DELAY);

  state_t                     state_q, state_d;
  logic [DATA_WIDTH_32-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH_32-1:0]   epc_q, epc_d;
  logic                       misaligned_q, misaligned_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH_32-1:0]   redirect_target;
  logic                       redirect;

  assign pc_plus4 = pc_q + DATA_WIDTH_32'(4);

  // Jump outranks branch; either one outranks halt and stall.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      ST_BOOT: begin
        pc_d = RESET_VECTOR;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trap) begin
          epc_d = pc_q;
          pc_d  = TRAP_VECTOR;
        end else if (redirect) begin
          // A target that is not word aligned becomes a trap instead of a fetch.
          if (redirect_target[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            epc_d        = pc_q;
            pc_d         = TRAP_VECTOR;
          end else begin
            pc_d = redirect_target;
          end
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      ST_HALT: begin
        if (trap) begin
          epc_d   = pc_q;
          pc_d    = TRAP_VECTOR;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = RESET_STATE;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RESET_STATE;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
      cnt_q        <= BOOT_CNT;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign epc         = epc_q;
  assign misaligned  = misaligned_q;
  assign state       = state_q;
  assign fetch_valid = (state_q == ST_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot hold, redirects, traps, halt, wrap and
// asynchronous reset, plus a zero-boot-delay instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        trap = 1'b0;
  logic        halt = 1'b0;

  logic [31:0] pc, pc_plus4, epc;
  logic        fetch_valid, misaligned;
  logic [1:0]  state;

  logic [31:0] pc0, pc_plus4_0, epc0;
  logic        fetch_valid0, misaligned0;
  logic [1:0]  state0;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.BOOT_DELAY(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .trap(trap), .halt(halt), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .epc(epc), .misaligned(misaligned), .state(state)
  );

  pc_sequencer #(.BOOT_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .trap(trap), .halt(halt), .pc(pc0), .pc_plus4(pc_plus4_0),
    .fetch_valid(fetch_valid0), .epc(epc0), .misaligned(misaligned0), .state(state0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    stall = 0; branch_taken = 0; jump = 0; trap = 0; halt = 0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    clear_req();
    jump = 1; jump_target = target;
    step();
    clear_req();
    checks++;
    if (pc !== target) begin
      errors++; $display("FAIL goto_pc: pc=%h expected %h", pc, target);
    end
  endtask

  task automatic test_reset();
    clear_req();
    rst = 0;
    step(); step();
    checks++;
    if ({pc, epc, state, fetch_valid, misaligned} !== {32'h0, 32'h0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: pc=%h epc=%h st=%0d fv=%b mis=%b expected 0/0/0/0/0",
                         pc, epc, state, fetch_valid, misaligned);
    end
    checks++;
    if ({state0, fetch_valid0} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL reset_state_delay0: st=%0d fv=%b expected 1/1", state0, fetch_valid0);
    end
    rst = 1;
    #1;
    checks++;
    if ({pc, state, fetch_valid} !== {32'h0, 2'd0, 1'b0}) begin
      errors++; $display("FAIL boot_before_edge0: pc=%h st=%0d fv=%b expected 0/0/0", pc, state, fetch_valid);
    end
    checks++;
    if (fetch_valid0 !== 1'b1) begin
      errors++; $display("FAIL delay0_fetch_valid: fv=%b expected 1", fetch_valid0);
    end
    step();
    checks++;
    if ({pc, state, fetch_valid} !== {32'h0, 2'd0, 1'b0}) begin
      errors++; $display("FAIL boot_after_edge0: pc=%h st=%0d fv=%b expected 0/0/0", pc, state, fetch_valid);
    end
    step();
    checks++;
    if ({pc, state, fetch_valid} !== {32'h0, 2'd1, 1'b1}) begin
      errors++; $display("FAIL boot_to_run: pc=%h st=%0d fv=%b expected 0/1/1", pc, state, fetch_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc !== 32'(4 * i)) begin
        errors++; $display("FAIL run_increment: pc=%h expected %h", pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    goto_pc(32'h8);
    jump = 1; jump_target = 32'h40; stall = 1;
    step();
    clear_req();
    checks++;
    if (pc !== 32'h40) begin
      errors++; $display("FAIL jump_over_stall: pc=%h expected 00000040", pc);
    end
    branch_taken = 1; branch_target = 32'h3;
    step();
    clear_req();
    checks++;
    if ({pc, epc, misaligned} !== {32'h100, 32'h40, 1'b1}) begin
      errors++; $display("FAIL branch_misaligned: pc=%h epc=%h mis=%b expected 100/40/1", pc, epc, misaligned);
    end
    step();
    checks++;
    if ({pc, misaligned} !== {32'h104, 1'b0}) begin
      errors++; $display("FAIL misaligned_pulse_end: pc=%h mis=%b expected 104/0", pc, misaligned);
    end
    jump = 1; jump_target = 32'h2;
    step();
    checks++;
    if ({pc, epc, misaligned} !== {32'h100, 32'h104, 1'b1}) begin
      errors++; $display("FAIL b2b_misaligned_1: pc=%h epc=%h mis=%b expected 100/104/1", pc, epc, misaligned);
    end
    step();
    clear_req();
    checks++;
    if ({pc, epc, misaligned} !== {32'h100, 32'h100, 1'b1}) begin
      errors++; $display("FAIL b2b_misaligned_2: pc=%h epc=%h mis=%b expected 100/100/1", pc, epc, misaligned);
    end
    branch_taken = 1; branch_target = 32'h200; halt = 1;
    step();
    clear_req();
    checks++;
    if ({pc, state, misaligned} !== {32'h200, 2'd1, 1'b0}) begin
      errors++; $display("FAIL branch_over_halt: pc=%h st=%0d mis=%b expected 200/1/0", pc, state, misaligned);
    end
  endtask

  task automatic test_trap();
    goto_pc(32'h20);
    trap = 1; jump = 1; jump_target = 32'h40;
    step();
    clear_req();
    checks++;
    if ({pc, epc, misaligned} !== {32'h100, 32'h20, 1'b0}) begin
      errors++; $display("FAIL trap_over_jump: pc=%h epc=%h mis=%b expected 100/20/0", pc, epc, misaligned);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pc, fetch_valid} !== {32'h100, 1'b1}) begin
        errors++; $display("FAIL stall_hold: pc=%h fv=%b expected 100/1", pc, fetch_valid);
      end
    end
    clear_req();
  endtask

  task automatic test_halt();
    goto_pc(32'h24);
    halt = 1;
    step();
    clear_req();
    checks++;
    if ({pc, state, fetch_valid} !== {32'h24, 2'd2, 1'b0}) begin
      errors++; $display("FAIL halt_enter: pc=%h st=%0d fv=%b expected 24/2/0", pc, state, fetch_valid);
    end
    jump = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h90;
    step();
    clear_req();
    checks++;
    if ({pc, state} !== {32'h24, 2'd2}) begin
      errors++; $display("FAIL halt_ignores_redirect: pc=%h st=%0d expected 24/2", pc, state);
    end
    trap = 1;
    step();
    clear_req();
    checks++;
    if ({pc, epc, state, fetch_valid} !== {32'h100, 32'h24, 2'd1, 1'b1}) begin
      errors++; $display("FAIL halt_trap_exit: pc=%h epc=%h st=%0d fv=%b expected 100/24/1/1",
                         pc, epc, state, fetch_valid);
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL pc_plus4_wrap: pc_plus4=%h expected 00000000", pc_plus4);
    end
    step();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: pc=%h expected 00000000", pc);
    end
  endtask

  task automatic test_async_reset();
    goto_pc(32'h300);
    step();
    #2;
    rst = 0;
    #1;
    checks++;
    if ({pc, epc, state, fetch_valid, misaligned} !== {32'h0, 32'h0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset: pc=%h epc=%h st=%0d fv=%b mis=%b expected 0/0/0/0/0",
                         pc, epc, state, fetch_valid, misaligned);
    end
    step();
    rst = 1;
    step(); step();
    checks++;
    if ({pc, state} !== {32'h0, 2'd1}) begin
      errors++; $display("FAIL reboot_run: pc=%h st=%0d expected 0/1", pc, state);
    end
    step();
    checks++;
    if (pc !== 32'h4) begin
      errors++; $display("FAIL reboot_increment: pc=%h expected 00000004", pc);
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_trap();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
